// File: rtl/fifo_rd_drain.sv
// Read-side FIFO consumer: pops words, absorbs the 1-cycle read latency in a 2-entry skid buffer
// and streams them out on valid/ready. Optional RD_DRAIN_STATS_EN adds the rd_count pop counter.
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_WIDTH = 4,
  parameter int BURST_MIN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  empty,
  input  logic [FIFO_WIDTH-1:0] f_counter,
  input  logic                  underflow,
  input  logic [DATA_WIDTH-1:0] fifo_out,
  output logic                  rd_enb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  err,
  input  logic                  err_clr
`ifdef RD_DRAIN_STATS_EN
  ,
  output logic [15:0]           rd_count
`endif
);

  localparam logic [FIFO_WIDTH-1:0] BURST_MIN_C = FIFO_WIDTH'(BURST_MIN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t                state_r;
  logic [1:0]            occ_r;
  logic                  inf_r;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;
  logic                  err_r;

  logic                  pop_s;
  logic                  start_s;
  logic                  rd_enb_s;
  logic [2:0]            level_s;

  // Pop/issue decisions; level_s is the skid occupancy once this cycle settles
  always_comb begin
    pop_s    = (occ_r != 2'd0) && out_ready;
    level_s  = {1'b0, occ_r} + {2'b00, inf_r} - {2'b00, pop_s};
    rd_enb_s = (state_r == ST_READ) && !empty && (level_s < 3'd2);
    start_s  = en && !empty && ((f_counter >= BURST_MIN_C) || flush);
  end

  assign rd_enb    = rd_enb_s;
  assign out_valid = (occ_r != 2'd0);
  assign out_data  = head_r;
  assign err       = err_r;

  // Burst control FSM; underflow overrides every other transition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else if (underflow) begin
      state_r <= ST_ERR;
    end else begin
      case (state_r)
        ST_IDLE: if (start_s) state_r <= ST_READ;
        ST_READ: if (empty || !en) state_r <= ST_IDLE;
        ST_ERR:  if (err_clr) state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Skid buffer: head is presented downstream, tail only fills while head is stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_r  <= 2'd0;
      inf_r  <= 1'b0;
      head_r <= '0;
      tail_r <= '0;
    end else begin
      inf_r <= rd_enb_s;
      case ({inf_r, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) head_r <= fifo_out;
          else               tail_r <= fifo_out;
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          head_r <= tail_r;
          occ_r  <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            head_r <= fifo_out;
          end else begin
            head_r <= tail_r;
            tail_r <= fifo_out;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

  // Sticky error flag; a new underflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else if (underflow) begin
      err_r <= 1'b1;
    end else if (err_clr) begin
      err_r <= 1'b0;
    end
  end

`ifdef RD_DRAIN_STATS_EN
  logic [15:0] rd_count_r;

  // Downstream pop counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count_r <= 16'd0;
    end else if (err_clr) begin
      rd_count_r <= 16'd0;
    end else if (pop_s) begin
      rd_count_r <= rd_count_r + 16'd1;
    end
  end

  assign rd_count = rd_count_r;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain: behavioural FIFO model feeding the DUT and an in-order
// scoreboard on the downstream stream.
module tb_fifo_rd_drain;
  localparam int DW   = 8;
  localparam int FW   = 4;
  localparam int BMIN = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          empty = 1'b1;
  logic [FW-1:0] f_counter = '0;
  logic          underflow = 1'b0;
  logic [DW-1:0] fifo_out = '0;
  logic          out_ready = 1'b0;
  logic          err_clr = 1'b0;
  logic          rd_enb;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          err;
`ifdef RD_DRAIN_STATS_EN
  logic [15:0]   rd_count;
`endif

  fifo_rd_drain #(.DATA_WIDTH(DW), .FIFO_WIDTH(FW), .BURST_MIN(BMIN)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .empty(empty), .f_counter(f_counter),
    .underflow(underflow), .fifo_out(fifo_out), .rd_enb(rd_enb), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err(err), .err_clr(err_clr)
`ifdef RD_DRAIN_STATS_EN
    , .rd_count(rd_count)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n, rx_cnt, first_rd, first_vld, last_vld;

  typedef struct {
    int   nwords;
    logic en;
    logic flush;
    logic exp_rd;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic upd_flags();
    empty     = (fifo_q.size() == 0);
    f_counter = (fifo_q.size() > 15) ? 4'd15 : 4'(fifo_q.size());
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 8'(i));
    upd_flags();
  endtask

  task automatic start_seq();
    rx_cnt = 0; first_rd = -1; first_vld = -1; last_vld = -1; cyc_n = 0;
  endtask

  // One clock: sample at negedge+1, clock edge, then the FIFO model answers a pop
  task automatic cyc();
    logic will_pop;
    #1;
    will_pop = rd_enb;
    if (will_pop && first_rd < 0) first_rd = cyc_n;
    if (out_valid && out_ready) begin
      if (first_vld < 0) first_vld = cyc_n;
      last_vld = cyc_n;
      rx_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none", out_data);
      end else begin
        chk("data_order", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    if (will_pop && fifo_q.size() > 0) begin
      fifo_out = fifo_q.pop_front();
      exp_q.push_back(fifo_out);
    end
    upd_flags();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fifo_q.delete(); exp_q.delete();
    fifo_out = '0; en = 1'b0; flush = 1'b0; out_ready = 1'b0;
    underflow = 1'b0; err_clr = 1'b0;
    upd_flags();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0,  1'b1, 1'b1, 1'b0};
    vt[1] = '{3,  1'b1, 1'b0, 1'b0};
    vt[2] = '{3,  1'b1, 1'b1, 1'b1};
    vt[3] = '{4,  1'b1, 1'b0, 1'b1};
    vt[4] = '{8,  1'b0, 1'b0, 1'b0};
    vt[5] = '{8,  1'b0, 1'b1, 1'b0};
    vt[6] = '{1,  1'b1, 1'b1, 1'b1};
    vt[7] = '{15, 1'b1, 1'b0, 1'b1};

    // Reset values
    @(negedge clk);
    #1;
    chk("reset_rd_enb", 32'(rd_enb), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    // Burst start table: idle cycle never reads, then threshold/flush/en decide
    for (int i = 0; i < 8; i++) begin
      do_reset();
      start_seq();
      load(8'h40, vt[i].nwords);
      en = vt[i].en; flush = vt[i].flush; out_ready = 1'b1;
      #1;
      chk($sformatf("idle_rd_enb[%0d]", i), 32'(rd_enb), 32'd0);
      cyc();
      flush = 1'b0;
      #1;
      chk($sformatf("start_rd_enb[%0d]", i), 32'(rd_enb), 32'(vt[i].exp_rd));
    end

    // Streaming 0x01..0x08 at one word per cycle
    do_reset();
    start_seq();
    load(8'h01, 8);
    en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 30 && rx_cnt < 8; k++) cyc();
    chk("stream_count", 32'(rx_cnt), 32'd8);
    chk("stream_latency", 32'(first_vld - first_rd), 32'd2);
    chk("stream_back_to_back", 32'(last_vld - first_vld), 32'd7);

    // Backpressure mid-stream for 5 cycles
    do_reset();
    start_seq();
    load(8'h11, 10);
    en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20 && rx_cnt < 3; k++) cyc();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall_rd_enb[%0d]", k), 32'(rd_enb), 32'd0);
      cyc();
    end
    #1;
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 30 && rx_cnt < 10; k++) cyc();
    chk("stall_total", 32'(rx_cnt), 32'd10);
    chk("stall_leftover", 32'(exp_q.size()), 32'd0);

    // Async reset with a full skid buffer
    do_reset();
    start_seq();
    load(8'h21, 10);
    en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20 && rx_cnt < 2; k++) cyc();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    rst = 1'b0;
    #1;
    chk("arst_rd_enb", 32'(rd_enb), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    fifo_q.delete(); exp_q.delete();
    upd_flags();
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    start_seq();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("arst_empty_rd_enb[%0d]", k), 32'(rd_enb), 32'd0);
      chk($sformatf("arst_empty_valid[%0d]", k), 32'(out_valid), 32'd0);
      cyc();
    end
    load(8'h31, 4);
    for (int k = 0; k < 20 && rx_cnt < 4; k++) cyc();
    chk("arst_restart_count", 32'(rx_cnt), 32'd4);

    // Underflow during READ, sticky err, set-wins, clear back to IDLE
    do_reset();
    start_seq();
    load(8'h51, 12);
    en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20 && rx_cnt < 2; k++) cyc();
    underflow = 1'b1;
    cyc();
    underflow = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("err_rd_enb[%0d]", k), 32'(rd_enb), 32'd0);
      chk($sformatf("err_flag[%0d]", k), 32'(err), 32'd1);
      cyc();
    end
    underflow = 1'b1; err_clr = 1'b1;
    cyc();
    underflow = 1'b0; err_clr = 1'b0;
    #1;
    chk("err_set_wins", 32'(err), 32'd1);
    chk("err_still_blocked", 32'(rd_enb), 32'd0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    #1;
    chk("err_cleared", 32'(err), 32'd0);
    chk("err_idle_rd_enb", 32'(rd_enb), 32'd0);
    cyc();
    #1;
    chk("err_resume_rd_enb", 32'(rd_enb), 32'd1);
    for (int k = 0; k < 40 && rx_cnt < 12; k++) cyc();
    chk("err_total", 32'(rx_cnt), 32'd12);

`ifdef RD_DRAIN_STATS_EN
    // Pop counter: count, clear on err_clr, 16-bit wrap
    do_reset();
    start_seq();
    #1;
    chk("stats_reset", 32'(rd_count), 32'd0);
    load(8'h61, 10);
    en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 30 && rx_cnt < 10; k++) cyc();
    #1;
    chk("stats_ten", 32'(rd_count), 32'd10);
    out_ready = 1'b0; err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    #1;
    chk("stats_clear", 32'(rd_count), 32'd0);
    rx_cnt = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 70000 && rx_cnt < 65536; k++) begin
      if (fifo_q.size() < 8) load(8'(k), 4);
      cyc();
    end
    #1;
    chk("stats_wrap_pops", 32'(rx_cnt), 32'd65536);
    chk("stats_wrap", 32'(rd_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
